// File: rtl/booth_seq_accum.sv
// Sequential radix-4 Booth multiplier, 32x32 signed -> 64-bit signed.
// The encoder sits outside: this block drives the triplet and multiplicand, then accumulates the returned partial product.
module booth_seq_accum (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic [2:0]  bits_out,
   output logic [31:0] m_out,
   input  logic [63:0] partial_in,
   output logic        busy,
   output logic        done,
   output logic [63:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [32:0] r_shift;
   logic [63:0] r_acc;
   logic [63:0] r_product;
   logic [3:0]  r_count;
   logic [31:0] r_m;
   logic        r_busy;
   logic        r_done;

   logic [4:0]  w_shamt;
   logic [63:0] w_acc_next;

   // Digit k carries weight 4^k, so the partial product is shifted by 2k; the sum wraps mod 2^64.
   assign w_shamt    = {r_count, 1'b0};
   assign w_acc_next = r_acc + (partial_in << w_shamt);

   // NOTE: every register here is cleared by the asynchronous reset and updated with
   // non-blocking assignments, so all state moves together on the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_count   <= '0;
         r_m       <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_m     <= multiplicand;
                  r_shift <= {multiplier, 1'b0};
                  r_acc   <= '0;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_acc   <= w_acc_next;
               r_shift <= {{2{r_shift[32]}}, r_shift[32:2]};
               r_count <= r_count + 4'd1;
               if (r_count == 4'd15) begin
                  r_product <= w_acc_next;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bits_out = r_shift[2:0];
   assign m_out    = r_m;
   assign busy     = r_busy;
   assign done     = r_done;
   assign product  = r_product;

endmodule

// File: tb/tb_booth_seq_accum.sv
// Self-checking bench for booth_seq_accum: table vectors, corner sequences and random
// operands compared with a plain signed-multiply reference.
module tb_booth_seq_accum;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [2:0]  bits_out;
   logic [31:0] m_out;
   logic [63:0] partial_in;
   logic        busy;
   logic        done;
   logic [63:0] product;

   booth_seq_accum dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .bits_out     (bits_out),
      .m_out        (m_out),
      .partial_in   (partial_in),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Booth encoder model returning the sign-extended partial product.
   logic signed [63:0] w_sm;
   assign w_sm = {{32{m_out[31]}}, m_out};
   always_comb begin
      partial_in = '0;
      case (bits_out)
         3'b001, 3'b010: partial_in = w_sm;
         3'b011:         partial_in = w_sm <<< 1;
         3'b100:         partial_in = -(w_sm <<< 1);
         3'b101, 3'b110: partial_in = -w_sm;
         default:        partial_in = '0;
      endcase
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] y);
      logic signed [63:0] sm;
      logic signed [63:0] sy;
      sm = {{32{m[31]}}, m};
      sy = {{32{y[31]}}, y};
      return sm * sy;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Results of the most recent operation.
   logic [2:0]  seen_bits [16];
   int          t_lat;
   int          t_busy;
   logic        t_m_stable;
   logic        t_prod_held;
   logic        t_idle_after;
   logic [63:0] t_prod;

   // Runs one multiply; start is re-pulsed with other operands at cycles poke_a/poke_b
   // (cycle 0 is the first RUN cycle, cycle 16 is the DONE cycle).
   task automatic do_mul(input logic [31:0] m, input logic [31:0] y,
                         input int poke_a, input int poke_b);
      logic [63:0] prev;
      prev = product;
      @(negedge clk);
      multiplicand = m;
      multiplier   = y;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      t_lat = -1; t_busy = 0; t_m_stable = 1'b1; t_prod_held = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (busy) t_busy++;
         if (c < 16) seen_bits[c] = bits_out;
         if (m_out !== m) t_m_stable = 1'b0;
         start = (c == poke_a || c == poke_b);
         if (start) begin
            multiplicand = ~m;
            multiplier   = ~y;
         end
         if (done) begin
            t_lat = c;
            break;
         end
         if (product !== prev) t_prod_held = 1'b0;
         @(negedge clk);
      end
      t_prod = product;
      @(negedge clk);
      start        = 1'b0;
      t_idle_after = !busy && !done;
   endtask

   task automatic check_op(input string name, input logic [63:0] exp, input bit full);
      check({name, " product"}, t_prod, exp);
      check({name, " latency"}, 64'(t_lat), 64'd16);
      if (full) begin
         check({name, " busy_cycles"}, 64'(t_busy), 64'd17);
         check({name, " m_out_stable"}, 64'(t_m_stable), 64'd1);
         check({name, " product_held"}, 64'(t_prod_held), 64'd1);
         check({name, " idle_after"}, 64'(t_idle_after), 64'd1);
      end
   endtask

   typedef struct {
      logic [31:0] m;
      logic [31:0] y;
      logic [63:0] p;
   } vec_t;

   vec_t vecs [8];
   logic [2:0] exp_b [16];
   logic       no_done;

   initial begin
      vecs[0] = '{32'd3,         32'd5,         64'd15};
      vecs[1] = '{32'd6,         32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
      vecs[3] = '{32'd2,         32'h8000_0000, 64'hFFFF_FFFF_0000_0000};
      vecs[4] = '{32'd1,         32'h0000_000B, 64'd11};
      vecs[5] = '{32'd0,         32'h1234_5678, 64'd0};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

      rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
      repeat (3) @(negedge clk);
      check("reset busy",     64'(busy), 64'd0);
      check("reset done",     64'(done), 64'd0);
      check("reset product",  product, 64'd0);
      check("reset bits_out", 64'(bits_out), 64'd0);
      check("reset m_out",    64'(m_out), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_mul(vecs[i].m, vecs[i].y, -1, -1);
         check_op($sformatf("vec%0d", i), vecs[i].p, 1'b1);
         if (i == 3) check("vec3 bits_k15", 64'(seen_bits[15]), 64'(3'b100));
         if (i == 4) begin
            for (int k = 0; k < 16; k++) exp_b[k] = 3'b000;
            exp_b[0] = 3'b110; exp_b[1] = 3'b101; exp_b[2] = 3'b001;
            for (int k = 0; k < 16; k++)
               check($sformatf("vec4 bits_k%0d", k), 64'(seen_bits[k]), 64'(exp_b[k]));
         end
      end

      // Start re-asserted at k=5 and during DONE must be ignored.
      do_mul(32'd5, 32'd9, 5, 16);
      check_op("poke", 64'd45, 1'b1);
      do_mul(32'd3, 32'd3, -1, -1);
      check_op("after_poke", 64'd9, 1'b1);

      // Reset in the middle of RUN.
      @(negedge clk);
      multiplicand = 32'd7; multiplier = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy",     64'(busy), 64'd0);
      check("midrst done",     64'(done), 64'd0);
      check("midrst product",  product, 64'd0);
      check("midrst bits_out", 64'(bits_out), 64'd0);
      check("midrst m_out",    64'(m_out), 64'd0);
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("rst start ignored", 64'(busy), 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      no_done = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done || busy) no_done = 1'b0;
      end
      check("midrst no_done", 64'(no_done), 64'd1);
      do_mul(32'd4, 32'd4, -1, -1);
      check_op("post_rst", 64'd16, 1'b1);

      // Random operands against the reference multiply.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] rm, ry;
         rm = pick();
         ry = pick();
         do_mul(rm, ry, -1, -1);
         check_op($sformatf("rand%0d", i), ref_mul(rm, ry), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/booth_seq_accum.md
BOOTH_SEQ_ACCUM -- requirements
Module: booth_seq_accum

Interface
REQ-001 The block SHALL have no parameters; operand widths are fixed at 32x32 signed, with a 64-bit signed product.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a multiply.
REQ-005 multiplicand  input  32  signed M, sampled on the accepted start.
REQ-006 multiplier  input  32  signed Y, sampled on the accepted start.
REQ-007 bits_out  output  3  current Booth triplet driven to the encoder stage.
REQ-008 m_out  output  32  latched multiplicand driven to the encoder stage.
REQ-009 partial_in  input  64  sign-extended partial product returned combinationally by the encoder for bits_out/m_out.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; product valid.
REQ-012 product  output  64  signed M*Y, held until the next completion.

Function
REQ-013 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch M into m_out, load the shift register with {Y,1'b0} (33 bits), clear acc and count, and go to RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 bits_out SHALL equal shift register bits [2:0], i.e. {Y[2k+1],Y[2k],Y[2k-1]} with Y[-1]=0, where k is the current count.
REQ-017 On each RUN edge: acc <= acc + (partial_in << 2k), truncated to 64 bits; shift register >> 2 (arithmetic); count <= count+1.
REQ-018 RUN SHALL last exactly 16 edges (k=0..15); the edge with k=15 SHALL also load product with the final acc sum and move the state to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-020 Latency: start sampled at edge E0 -> done high in the cycle after E16 -> IDLE after E17.
REQ-021 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-022 start while busy=1, including during DONE, SHALL be ignored with no effect on state, acc, product or the latched operands.
REQ-023 product SHALL change only at the completing edge; it holds the previous result throughout RUN.
REQ-024 m_out SHALL be stable from the accepting edge through DONE.
REQ-025 acc overflow beyond 64 bits SHALL wrap mod 2^64; no saturation or flagging.
REQ-026 The block SHALL NOT terminate early; zero or all-ones triplets still consume a cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, product=0, acc=0, count=0, shift register=0 (bits_out=3'b000), m_out=0.
REQ-028 Reset mid-RUN or mid-DONE SHALL abandon the operation with no done pulse; the first start after rst_n rises SHALL operate normally.
REQ-029 While rst_n=0, start SHALL be ignored.

Verification
The bench drives partial_in from an encoder model: 000/111->0; 001/010->sext(M); 011->sext(2M); 100->-sext(2M); 101/110->-sext(M).
REQ-030 M=3, Y=5, start at E0 -> done pulses only in the cycle after E16; product=64'd15; busy high for 17 cycles.
REQ-031 M=6, Y=-7 -> product=64'hFFFFFFFF_FFFFFFD6 (-42); M=-1, Y=-1 -> product=64'd1.
REQ-032 M=2, Y=32'h80000000 -> bits_out for k=15 is 3'b100; product=64'hFFFFFFFF_00000000.
REQ-033 Y=32'h0000000B -> bits_out sequence 110, 101, 001, then 000 x13; with M=1 -> product=64'd11.
REQ-034 start re-asserted at k=5 and in the DONE cycle -> both ignored; the first result completes unchanged; the next start in IDLE is accepted with normal latency.
REQ-035 rst_n pulsed low at k=8 -> all outputs 0 asynchronously, no done pulse; a following M=4, Y=4 run -> product=64'd16.
